// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit that owns the HI/LO pair: one shift-add or
// restoring-subtract step per clock, with sign fix-up in a final cycle.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             hilo_rd,
    input  logic             cancel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             busy_q, done_q;
    logic             is_div_q, neg_q, rem_neg_q, div0_q;
    logic [WIDTH-1:0] a_raw_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH:0]   upper_q;
    logic [WIDTH-1:0] lower_q;

    logic             sgn_op;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH:0]   upper_d;
    logic [WIDTH-1:0] lower_d;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    logic [WIDTH-1:0] hi_fix, lo_fix;

    assign sgn_op = ~op[0];
    assign a_abs  = (sgn_op && a[WIDTH-1]) ? -a : a;
    assign b_abs  = (sgn_op && b[WIDTH-1]) ? -b : b;

    // Mult: {upper,lower} is the running product with the multiplier shifting
    // out of lower. Div: upper is the partial remainder, lower the dividend
    // shifting out while quotient bits shift in.
    always_comb begin
        mul_sum   = upper_q + (lower_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {upper_q[WIDTH-1:0], lower_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        upper_d   = {1'b0, mul_sum[WIDTH:1]};
        lower_d   = {mul_sum[0], lower_q[WIDTH-1:1]};
        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                upper_d = div_diff;
                lower_d = {lower_q[WIDTH-2:0], 1'b1};
            end else begin
                upper_d = div_shift;
                lower_d = {lower_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod     = {upper_q[WIDTH-1:0], lower_q};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -lower_q : lower_q;
        rem_fix  = rem_neg_q ? -upper_q[WIDTH-1:0] : upper_q[WIDTH-1:0];
        hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
        lo_fix   = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            // Divide by zero returns the raw dividend regardless of signedness.
            hi_fix = div0_q ? a_raw_q : rem_fix;
            lo_fix = div0_q ? '1 : quo_fix;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            a_raw_q   <= '0;
            opnd_q    <= '0;
            upper_q   <= '0;
            lower_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !cancel) begin
                        state_q   <= CALC;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        is_div_q  <= op[1];
                        neg_q     <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rem_neg_q <= sgn_op & op[1] & a[WIDTH-1];
                        div0_q    <= op[1] & (b == '0);
                        a_raw_q   <= a;
                        upper_q   <= '0;
                        opnd_q    <= op[1] ? b_abs : a_abs;
                        lower_q   <= op[1] ? a_abs : b_abs;
                    end else if (!start) begin
                        if (mthi) hi_q <= wdata;
                        if (mtlo) lo_q <= wdata;
                    end
                end
                CALC: begin
                    if (cancel) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        upper_q <= upper_d;
                        lower_q <= lower_d;
                        cnt_q   <= cnt_q + CW'(1);
                        if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (!cancel) begin
                        hi_q   <= hi_fix;
                        lo_q   <= lo_fix;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign stall = busy_q & (start | mthi | mtlo | hilo_rd);

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized and directed checks of muldiv_seq against an arithmetic model,
// with results queued at launch and compared by a done-driven monitor.
module tb_muldiv_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, mthi, mtlo, hilo_rd, cancel;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
    logic [W-1:0] hi, lo;
    logic         busy, done, stall;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .hilo_rd(hilo_rd),
        .cancel(cancel), .hi(hi), .lo(lo), .busy(busy), .done(done),
        .stall(stall)
    );

    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_err = 0;
    logic [63:0]  exp_q[$];
    logic [63:0]  mon_e;
    logic [W-1:0] hi_m, lo_m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Signed results come from 64-bit signed arithmetic; SV division
    // truncates toward zero and % takes the dividend's sign.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        longint          sx, sy, q, r;
        longint unsigned ux, uy, uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'h0, x};
        uy = {32'h0, y};
        if (o[1] && y == 32'h0) return {x, 32'hFFFF_FFFF};
        case (o)
            2'b00: return 64'(sx * sy);
            2'b01: return ux * uy;
            2'b10: begin
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                uq = ux / uy;
                ur = ux % uy;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                mon_e = exp_q.pop_front();
                $display("result hi=%h lo=%h expected %h", hi, lo, mon_e);
                check("res_hi", 64'(hi), 64'(mon_e[63:32]));
                check("res_lo", 64'(lo), 64'(mon_e[31:0]));
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int poke, input bit rnd, input bit with_mt);
        int cyc;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        mthi = with_mt; mtlo = with_mt; wdata = $urandom;
        exp_q.push_back(ref_model(o, x, y));
        {hi_m, lo_m} = ref_model(o, x, y);
        $display("launch op=%0d a=%h b=%h", o, x, y);
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        a = $urandom; b = $urandom;
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            if (cyc == poke) begin
                start = 1'b1; op = 2'b00; mthi = 1'b1; wdata = 32'h55;
            end else if (rnd) begin
                start   = ($urandom_range(3) == 0);
                op      = 2'($urandom);
                mthi    = ($urandom_range(3) == 0);
                mtlo    = ($urandom_range(3) == 0);
                hilo_rd = ($urandom_range(3) == 0);
                wdata   = $urandom;
            end else begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0; hilo_rd = 1'b0;
            end
            #1;
            check("stall", 64'(stall), 64'(start | mthi | mtlo | hilo_rd));
            @(negedge clk);
        end
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0; hilo_rd = 1'b0;
        check("busy_cycles", 64'(cyc), 64'(W + 1));
    endtask

    task automatic mt_write(input bit h, input bit l, input logic [W-1:0] v);
        @(negedge clk);
        mthi = h; mtlo = l; wdata = v;
        if (h) hi_m = v;
        if (l) lo_m = v;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        $display("mt hi=%0d lo=%0d v=%h", h, l, v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] specials [6];
        logic [W-1:0] x, y;
        specials[0] = 32'h0000_0000; specials[1] = 32'hFFFF_FFFF;
        specials[2] = 32'h8000_0000; specials[3] = 32'h7FFF_FFFF;
        specials[4] = 32'h0000_0001; specials[5] = 32'hFFFF_FFFE;

        rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; hilo_rd = 1'b0;
        cancel = 1'b0; op = 2'b00; a = '0; b = '0; wdata = '0;
        hi_m = '0; lo_m = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_hi", 64'(hi), 64'h0);
        check("rst_lo", 64'(lo), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);

        mt_write(1'b1, 1'b1, 32'h1234);
        check("mt_both_hi", 64'(hi), 64'h1234);
        check("mt_both_lo", 64'(lo), 64'h1234);
        mt_write(1'b0, 1'b1, 32'h5678);
        check("mt_hi", 64'(hi), 64'h1234);
        check("mt_lo", 64'(lo), 64'h5678);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
        check("t1_hi", 64'(hi), 64'hFFFF_FFFE);
        check("t1_lo", 64'(lo), 64'h0000_0001);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 1'b0, 1'b0);
        check("t2m_hi", 64'(hi), 64'hFFFF_FFFF);
        check("t2m_lo", 64'(lo), 64'hFFFF_FFEB);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 1'b0);
        check("t2d_hi", 64'(hi), 64'hFFFF_FFFF);
        check("t2d_lo", 64'(lo), 64'hFFFF_FFFD);
        run_op(2'b11, 32'd100, 32'd0, 0, 1'b0, 1'b0);
        check("t3z_hi", 64'(hi), 64'd100);
        check("t3z_lo", 64'(lo), 64'hFFFF_FFFF);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
        check("t3o_hi", 64'(hi), 64'h0);
        check("t3o_lo", 64'(lo), 64'h8000_0000);
        run_op(2'b11, 32'd100, 32'd7, 5, 1'b0, 1'b0);
        check("t4_hi", 64'(hi), 64'd2);
        check("t4_lo", 64'(lo), 64'd14);
        run_op(2'b01, 32'd3, 32'd5, 0, 1'b0, 1'b1);
        check("start_vs_mt_lo", 64'(lo), 64'd15);

        // Cancel mid-operation: no result, HI/LO untouched.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = $urandom; b = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        $display("cancel issued");
        check("cancel_busy", 64'(busy), 64'h0);
        check("cancel_hi", 64'(hi), 64'(hi_m));
        check("cancel_lo", 64'(lo), 64'(lo_m));
        repeat (40) @(negedge clk);
        check("cancel_hold_lo", 64'(lo), 64'(lo_m));
        run_op(2'b00, $urandom, $urandom, 0, 1'b0, 1'b0);

        // Asynchronous reset mid-division.
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = $urandom; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        $display("reset mid-div");
        check("arst_hi", 64'(hi), 64'h0);
        check("arst_lo", 64'(lo), 64'h0);
        check("arst_busy", 64'(busy), 64'h0);
        hi_m = '0; lo_m = '0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            x = ($urandom_range(3) == 0) ? specials[$urandom_range(5)] : $urandom;
            y = ($urandom_range(3) == 0) ? specials[$urandom_range(5)] : $urandom;
            if ($urandom_range(1) == 0) y = y >> $urandom_range(31);
            run_op(2'($urandom), x, y, 0, 1'b1, ($urandom_range(3) == 0));
            repeat ($urandom_range(2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("pending", 64'(exp_q.size()), 64'h0);
        check("final_hi", 64'(hi), 64'(hi_m));
        check("final_lo", 64'(lo), 64'(lo_m));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
